// File: rtl/rle_decoder.sv
// Run-length decoder: expands {0,sample} literals and {1,n} repeat-count words
// into one sample per output beat, with ready/valid on both sides.
module rle_decoder #(
    parameter int unsigned CW     = 15,
    parameter int unsigned OCNT_W = 32
) (
    input  logic              core_clk,
    input  logic              core_rst,
    input  logic [CW:0]       rle_data,
    input  logic              rle_valid,
    output logic              rle_ready,
    output logic [CW-1:0]     dec_data,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic              dec_busy,
    output logic              err_orphan,
    output logic [OCNT_W-1:0] dec_count
);

    typedef enum logic {
        S_ACCEPT = 1'b0,
        S_EXPAND = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       last, last_nxt;
    logic [CW-1:0]       rem, rem_nxt;
    logic [CW-1:0]       dec_data_nxt;
    logic                dec_valid_nxt;
    logic                have_literal, have_literal_nxt;
    logic                err_orphan_nxt;
    logic [OCNT_W-1:0]   dec_count_nxt;

    logic                adv;
    logic                xfer;
    logic                is_count;
    logic [CW-1:0]       word_val;

    assign adv      = !dec_valid || dec_ready;
    assign xfer     = rle_valid && rle_ready;
    assign is_count = rle_data[CW];
    assign word_val = rle_data[CW-1:0];

    // State and datapath registers
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state        <= S_ACCEPT;
            last         <= '0;
            rem          <= '0;
            dec_data     <= '0;
            dec_valid    <= 1'b0;
            have_literal <= 1'b0;
            err_orphan   <= 1'b0;
            dec_count    <= '0;
        end else begin
            state        <= state_nxt;
            last         <= last_nxt;
            rem          <= rem_nxt;
            dec_data     <= dec_data_nxt;
            dec_valid    <= dec_valid_nxt;
            have_literal <= have_literal_nxt;
            err_orphan   <= err_orphan_nxt;
            dec_count    <= dec_count_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt        = state;
        last_nxt         = last;
        rem_nxt          = rem;
        dec_data_nxt     = dec_data;
        dec_valid_nxt    = dec_valid;
        have_literal_nxt = have_literal;
        err_orphan_nxt   = err_orphan;
        dec_count_nxt    = dec_count;

        if (dec_valid && dec_ready) begin
            dec_count_nxt = dec_count + OCNT_W'(1);
        end

        case (state)
            S_ACCEPT: begin
                if (xfer && !is_count) begin
                    dec_data_nxt     = word_val;
                    dec_valid_nxt    = 1'b1;
                    last_nxt         = word_val;
                    have_literal_nxt = 1'b1;
                end else if (xfer) begin
                    if (!have_literal) begin
                        err_orphan_nxt = 1'b1;
                    end
                    if (word_val == '0) begin
                        if (adv) begin
                            dec_valid_nxt = 1'b0;
                        end
                    end else begin
                        dec_data_nxt  = last;
                        dec_valid_nxt = 1'b1;
                        rem_nxt       = word_val - CW'(1);
                        if (word_val != CW'(1)) begin
                            state_nxt = S_EXPAND;
                        end
                    end
                end else if (adv) begin
                    dec_valid_nxt = 1'b0;
                end
            end
            S_EXPAND: begin
                if (adv) begin
                    dec_data_nxt  = last;
                    dec_valid_nxt = 1'b1;
                    rem_nxt       = rem - CW'(1);
                    if (rem == CW'(1)) begin
                        state_nxt = S_ACCEPT;
                    end
                end
            end
            default: state_nxt = S_ACCEPT;
        endcase
    end

    // Handshake outputs decoded from state and output-register advance
    always_comb begin
        rle_ready = 1'b0;
        dec_busy  = 1'b0;
        case (state)
            S_ACCEPT: rle_ready = adv && !core_rst;
            S_EXPAND: dec_busy  = 1'b1;
            default:  rle_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_rle_decoder.sv
// Bench for rle_decoder: hand-written vector table, multi-cycle corner sequences,
// and random word streams checked against a queue-based expansion model.
module tb_rle_decoder;

    logic        core_clk  = 1'b0;
    logic        core_rst  = 1'b1;
    logic [15:0] rle_data  = 16'h0;
    logic        rle_valid = 1'b0;
    logic        rle_ready;
    logic [14:0] dec_data;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic        dec_busy;
    logic        err_orphan;
    logic [31:0] dec_count;

    rle_decoder #(.CW(15), .OCNT_W(32)) dut (
        .core_clk   (core_clk),
        .core_rst   (core_rst),
        .rle_data   (rle_data),
        .rle_valid  (rle_valid),
        .rle_ready  (rle_ready),
        .dec_data   (dec_data),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_busy   (dec_busy),
        .err_orphan (err_orphan),
        .dec_count  (dec_count)
    );

    always #5 core_clk = ~core_clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int rdy_mode = 0;
    int ph = 0;

    logic [14:0] got_q[$];
    int          got_t[$];
    logic [14:0] exp_q[$];
    logic        exp_err;
    int          first_acc;
    int          last_stall;

    typedef struct {
        logic [15:0] w[4];
        int          nw;
        int          mode;
        logic [14:0] e[6];
        int          en;
        logic        err;
    } vec_t;

    vec_t vt[6];

    always @(posedge core_clk) cyc <= cyc + 1;

    // Downstream ready: 0 = always, 1 = random, 2 = pattern 1,0,0
    always @(posedge core_clk) begin
        #1;
        ph = ph + 1;
        case (rdy_mode)
            0:       dec_ready = 1'b1;
            1:       dec_ready = ($urandom_range(0, 3) != 0);
            default: dec_ready = ((ph % 3) == 0);
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Output monitor: records transfers and checks hold under backpressure
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [14:0] pd = '0;
    always @(negedge core_clk) begin
        if (core_rst) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) chk("stall_hold", 32'({dec_valid, dec_data}), 32'({1'b1, pd}));
            if (dec_valid && dec_ready) begin
                got_q.push_back(dec_data);
                got_t.push_back(cyc);
            end
            pv = dec_valid;
            pr = dec_ready;
            pd = dec_data;
        end
    end

    task automatic do_reset();
        rle_valid = 1'b0;
        core_rst  = 1'b1;
        @(negedge core_clk);
        chk("rst_rle_ready_low", 32'(rle_ready), 32'd0);
        @(posedge core_clk);
        #1;
        core_rst = 1'b0;
        got_q.delete();
        got_t.delete();
        @(negedge core_clk);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_busy", 32'(dec_busy), 32'd0);
        chk("rst_err_orphan", 32'(err_orphan), 32'd0);
        chk("rst_dec_count", dec_count, 32'd0);
        chk("rst_rle_ready_high", 32'(rle_ready), 32'd1);
        @(posedge core_clk);
        #1;
    endtask

    // Present one word and hold it until accepted; entered and left at posedge+1
    task automatic send(input logic [15:0] w, output int stalls);
        int s = 0;
        rle_valid = 1'b1;
        rle_data  = w;
        forever begin
            @(negedge core_clk);
            if (rle_ready) begin
                @(posedge core_clk);
                #1;
                break;
            end
            s++;
            if (s > 40000) begin
                chk("send_timeout", 32'(s), 32'd0);
                @(posedge core_clk);
                #1;
                break;
            end
            @(posedge core_clk);
            #1;
        end
        rle_valid = 1'b0;
        rle_data  = 16'($urandom);
        stalls    = s;
    endtask

    task automatic drain();
        int idle = 0;
        int n    = 0;
        while (idle < 4 && n < 40000) begin
            @(negedge core_clk);
            if (!dec_valid && !dec_busy) idle++;
            else idle = 0;
            n++;
        end
        chk("drain_timeout", 32'(idle < 4), 32'd0);
        @(posedge core_clk);
        #1;
    endtask

    task automatic run_words(input logic [15:0] words[$], input int mode);
        int st;
        do_reset();
        rdy_mode = mode;
        foreach (words[i]) begin
            send(words[i], st);
            if (i == 0) first_acc = cyc;
            last_stall = st;
        end
        drain();
    endtask

    // Reference: expand literals and repeat counts straight from the word rules
    task automatic model(input logic [15:0] w[$]);
        logic [14:0] lst = '0;
        logic        lit = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        foreach (w[i]) begin
            if (!w[i][15]) begin
                exp_q.push_back(w[i][14:0]);
                lst = w[i][14:0];
                lit = 1'b1;
            end else begin
                if (!lit) exp_err = 1'b1;
                repeat (int'(w[i][14:0])) exp_q.push_back(lst);
            end
        end
    endtask

    task automatic cmp_q(input string nm);
        int bad = -1;
        chk({nm, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i] && bad < 0) bad = i;
        end
        n_total++;
        if (bad < 0) n_pass++;
        else $display("FAIL %s_data beat %0d: got %0h expected %0h", nm, bad, got_q[bad], exp_q[bad]);
    endtask

    initial begin
        logic [15:0] words[$];
        int st;

        vt[0].w = '{16'h0005, 16'h8003, 16'h000A, 16'h0000}; vt[0].nw = 3; vt[0].mode = 0;
        vt[0].e = '{15'd5, 15'd5, 15'd5, 15'd5, 15'd10, 15'd0}; vt[0].en = 5; vt[0].err = 1'b0;
        vt[1].w = '{16'h0007, 16'h8000, 16'h0009, 16'h0000}; vt[1].nw = 3; vt[1].mode = 0;
        vt[1].e = '{15'd7, 15'd9, 15'd0, 15'd0, 15'd0, 15'd0}; vt[1].en = 2; vt[1].err = 1'b0;
        vt[2].w = '{16'h8002, 16'h0000, 16'h0000, 16'h0000}; vt[2].nw = 1; vt[2].mode = 0;
        vt[2].e = '{15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0}; vt[2].en = 2; vt[2].err = 1'b1;
        vt[3].w = '{16'h0003, 16'h8004, 16'h0000, 16'h0000}; vt[3].nw = 2; vt[3].mode = 2;
        vt[3].e = '{15'd3, 15'd3, 15'd3, 15'd3, 15'd3, 15'd0}; vt[3].en = 5; vt[3].err = 1'b0;
        vt[4].w = '{16'h0001, 16'h0001, 16'h8001, 16'h8001}; vt[4].nw = 4; vt[4].mode = 1;
        vt[4].e = '{15'd1, 15'd1, 15'd1, 15'd1, 15'd0, 15'd0}; vt[4].en = 4; vt[4].err = 1'b0;
        vt[5].w = '{16'h8000, 16'h0004, 16'h0000, 16'h0000}; vt[5].nw = 2; vt[5].mode = 0;
        vt[5].e = '{15'd4, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0}; vt[5].en = 1; vt[5].err = 1'b1;

        repeat (2) @(posedge core_clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            words.delete();
            for (int k = 0; k < vt[i].nw; k++) words.push_back(vt[i].w[k]);
            run_words(words, vt[i].mode);
            exp_q.delete();
            for (int k = 0; k < vt[i].en; k++) exp_q.push_back(vt[i].e[k]);
            cmp_q($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_err", i), 32'(err_orphan), 32'(vt[i].err));
            chk($sformatf("vec%0d_count", i), dec_count, 32'(vt[i].en));
            if (i == 0 && got_t.size() == 5) begin
                chk("vec0_latency", 32'(got_t[0]), 32'(first_acc));
                chk("vec0_span", 32'(got_t[4] - got_t[0]), 32'd4);
            end
        end

        // Maximum run: 0xFFFF repeats 32767 times and blocks input meanwhile
        do_reset();
        rdy_mode = 0;
        words = '{16'h1234, 16'hFFFF, 16'h0055};
        send(words[0], st);
        send(words[1], st);
        chk("max_accept_stall", 32'(st), 32'd0);
        @(negedge core_clk);
        chk("max_busy", 32'(dec_busy), 32'd1);
        @(posedge core_clk);
        #1;
        send(words[2], st);
        chk("max_ready_low_cycles", 32'(st + 1), 32'd32766);
        chk("max_count_at_next", dec_count, 32'd32768);
        drain();
        model(words);
        cmp_q("max_run");
        chk("max_count_final", dec_count, 32'd32769);

        // Reset in the middle of an expansion abandons the run
        do_reset();
        rdy_mode = 0;
        send(16'h0002, st);
        send(16'h8010, st);
        repeat (3) @(posedge core_clk);
        #1;
        @(negedge core_clk);
        chk("midrst_busy_before", 32'(dec_busy), 32'd1);
        @(posedge core_clk);
        #1;
        do_reset();
        repeat (20) @(posedge core_clk);
        #1;
        chk("midrst_no_beats", 32'(got_q.size()), 32'd0);
        chk("midrst_count", dec_count, 32'd0);

        // Random streams against the expansion model
        for (int s = 0; s < 25; s++) begin
            int nw;
            words.delete();
            nw = $urandom_range(1, 8);
            for (int k = 0; k < nw; k++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 5)      words.push_back({1'b0, 15'($urandom)});
                else if (r < 9) words.push_back({1'b1, 15'($urandom_range(0, 6))});
                else            words.push_back({1'b1, 15'($urandom_range(7, 60))});
            end
            run_words(words, $urandom_range(0, 2));
            model(words);
            cmp_q($sformatf("rnd%0d", s));
            chk($sformatf("rnd%0d_err", s), 32'(err_orphan), 32'(exp_err));
            chk($sformatf("rnd%0d_count", s), dec_count, 32'(exp_q.size()));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
